// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: MIPS opcode/funct fields, ALU operation codes, FSM states.
// ALU_ISSUE_IMM_EN enables I-type (immediate) decode.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_LUI   = 6'h0f;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2a;
  localparam logic [5:0] FN_MUL = 6'h2c;

  localparam logic [5:0] ALU_OPRN_ADD = 6'd1;
  localparam logic [5:0] ALU_OPRN_SUB = 6'd2;
  localparam logic [5:0] ALU_OPRN_MUL = 6'd3;
  localparam logic [5:0] ALU_OPRN_SRL = 6'd4;
  localparam logic [5:0] ALU_OPRN_SLL = 6'd5;
  localparam logic [5:0] ALU_OPRN_AND = 6'd6;
  localparam logic [5:0] ALU_OPRN_OR  = 6'd7;
  localparam logic [5:0] ALU_OPRN_NOR = 6'd8;
  localparam logic [5:0] ALU_OPRN_SLT = 6'd9;

`ifdef ALU_ISSUE_IMM_EN
  localparam bit IMM_DECODE_EN = 1'b1;
`else
  localparam bit IMM_DECODE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_instr_decode.sv
// Combinational MIPS instruction decoder: maps INSTR plus register operands to ALU OPRN/OP1/OP2.
// Immediate opcodes decode only when ALU_ISSUE_IMM_EN is defined; otherwise they flag illegal.
module alu_instr_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OPRN_W = 6
) (
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  output logic [OPRN_W-1:0] o_oprn,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2,
  output logic              o_illegal
);

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_shamt;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_shamt_ext;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;
  logic [DATA_W-1:0] w_imm_upper;
  logic              w_unused_fields;

  assign w_opcode    = i_instr[31:26];
  assign w_funct     = i_instr[5:0];
  assign w_shamt     = i_instr[10:6];
  assign w_imm       = i_instr[15:0];
  assign w_shamt_ext = {{(DATA_W-5){1'b0}}, w_shamt};
  assign w_imm_sext  = {{(DATA_W-16){w_imm[15]}}, w_imm};
  assign w_imm_zext  = {{(DATA_W-16){1'b0}}, w_imm};
  assign w_imm_upper = {w_imm, {(DATA_W-16){1'b0}}};
  // Register-number fields are resolved upstream by the register file read.
  assign w_unused_fields = ^i_instr[25:11];

  always_comb begin
    o_oprn    = '0;
    o_op1     = i_rs_data;
    o_op2     = i_rt_data;
    o_illegal = 1'b0;
    case (w_opcode)
      OPC_RTYPE: begin
        case (w_funct)
          FN_ADD: o_oprn = OPRN_W'(ALU_OPRN_ADD);
          FN_SUB: o_oprn = OPRN_W'(ALU_OPRN_SUB);
          FN_MUL: o_oprn = OPRN_W'(ALU_OPRN_MUL);
          FN_SRL: begin
            o_oprn = OPRN_W'(ALU_OPRN_SRL);
            o_op1  = i_rt_data;
            o_op2  = w_shamt_ext;
          end
          FN_SLL: begin
            o_oprn = OPRN_W'(ALU_OPRN_SLL);
            o_op1  = i_rt_data;
            o_op2  = w_shamt_ext;
          end
          FN_AND: o_oprn = OPRN_W'(ALU_OPRN_AND);
          FN_OR:  o_oprn = OPRN_W'(ALU_OPRN_OR);
          FN_NOR: o_oprn = OPRN_W'(ALU_OPRN_NOR);
          FN_SLT: o_oprn = OPRN_W'(ALU_OPRN_SLT);
          default: o_illegal = 1'b1;
        endcase
      end
      // Branch compare is a subtract; the consumer only looks at the zero flag.
      OPC_BEQ, OPC_BNE: o_oprn = OPRN_W'(ALU_OPRN_SUB);
      OPC_ADDI: begin
        o_oprn    = OPRN_W'(ALU_OPRN_ADD);
        o_op2     = w_imm_sext;
        o_illegal = !IMM_DECODE_EN;
      end
      OPC_SLTI: begin
        o_oprn    = OPRN_W'(ALU_OPRN_SLT);
        o_op2     = w_imm_sext;
        o_illegal = !IMM_DECODE_EN;
      end
      OPC_ANDI: begin
        o_oprn    = OPRN_W'(ALU_OPRN_AND);
        o_op2     = w_imm_zext;
        o_illegal = !IMM_DECODE_EN;
      end
      OPC_ORI: begin
        o_oprn    = OPRN_W'(ALU_OPRN_OR);
        o_op2     = w_imm_zext;
        o_illegal = !IMM_DECODE_EN;
      end
      OPC_LUI: begin
        o_oprn    = OPRN_W'(ALU_OPRN_OR);
        o_op1     = '0;
        o_op2     = w_imm_upper;
        o_illegal = !IMM_DECODE_EN;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Requester side of the combinational ALU: decode, hold operands for a settle window, return result via valid/ready.
// Define ALU_ISSUE_IMM_EN to add I-type decode (addi/slti/andi/ori/lui).
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int OPRN_W        = 6,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [31:0]       i_instr,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  output logic [DATA_W-1:0] o_alu_op1,
  output logic [DATA_W-1:0] o_alu_op2,
  output logic [OPRN_W-1:0] o_alu_oprn,
  input  logic [DATA_W-1:0] i_alu_out,
  input  logic              i_alu_zero,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_rsp_zero,
  output logic              o_rsp_err
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  issue_state_e      r_state;
  issue_state_e      w_next_state;
  logic [3:0]        r_cnt;
  logic [DATA_W-1:0] r_alu_op1;
  logic [DATA_W-1:0] r_alu_op2;
  logic [OPRN_W-1:0] r_alu_oprn;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_zero;
  logic              r_rsp_err;

  logic [OPRN_W-1:0] w_dec_oprn;
  logic [DATA_W-1:0] w_dec_op1;
  logic [DATA_W-1:0] w_dec_op2;
  logic              w_dec_illegal;
  logic              w_accept;
  logic              w_settle_done;

  alu_instr_decode #(
    .DATA_W(DATA_W),
    .OPRN_W(OPRN_W)
  ) u_decode (
    .i_instr   (i_instr),
    .i_rs_data (i_rs_data),
    .i_rt_data (i_rt_data),
    .o_oprn    (w_dec_oprn),
    .o_op1     (w_dec_op1),
    .o_op2     (w_dec_op2),
    .o_illegal (w_dec_illegal)
  );

  assign w_accept      = i_req_valid && (r_state == ST_IDLE);
  assign w_settle_done = (r_state == ST_DRIVE) && (r_cnt == SETTLE_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next_state = w_dec_illegal ? ST_RESP : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (w_settle_done) begin
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Illegal instructions skip the ALU entirely and leave the previous operands on the bus.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= '0;
      r_alu_op1  <= '0;
      r_alu_op2  <= '0;
      r_alu_oprn <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      if (w_dec_illegal) begin
        r_rsp_err  <= 1'b1;
        r_rsp_data <= '0;
        r_rsp_zero <= 1'b0;
      end else begin
        r_alu_op1  <= w_dec_op1;
        r_alu_op2  <= w_dec_op2;
        r_alu_oprn <= w_dec_oprn;
      end
    end else if (w_settle_done) begin
      r_rsp_data <= i_alu_out;
      r_rsp_zero <= i_alu_zero;
      r_rsp_err  <= 1'b0;
    end else if (r_state == ST_DRIVE) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign o_req_ready = (r_state == ST_IDLE);
  assign o_rsp_valid = (r_state == ST_RESP);
  assign o_alu_op1   = r_alu_op1;
  assign o_alu_op2   = r_alu_op2;
  assign o_alu_oprn  = r_alu_oprn;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_zero  = r_rsp_zero;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl paired with a behavioural ALU: table of single-instruction vectors on a
// SETTLE_CYCLES=1 instance, plus back-pressure and mid-operation reset sequences on a SETTLE_CYCLES=3 instance.
module tb_alu_issue_ctrl;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        legal;
    logic [5:0]  oprn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] data;
    logic        zero;
  } vec_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  logic        reqValidA, reqReadyA, aluZeroA, rspValidA, rspReadyA, rspZeroA, rspErrA;
  logic [31:0] instrA, rsDataA, rtDataA, aluOp1A, aluOp2A, aluOutA, rspDataA;
  logic [5:0]  aluOprnA;
  logic        reqValidB, reqReadyB, aluZeroB, rspValidB, rspReadyB, rspZeroB, rspErrB;
  logic [31:0] instrB, rsDataB, rtDataB, aluOp1B, aluOp2B, aluOutB, rspDataB;
  logic [5:0]  aluOprnB;

  int checks = 0;
  int errors = 0;
  logic [5:0]  heldOprn;
  logic [31:0] heldOp1;
  logic [31:0] heldOp2;
  vec_t vecs[$];

  // Behavioural stand-in for the external combinational ALU.
  function automatic logic [31:0] aluModel(input logic [5:0] oprn, input logic [31:0] a, input logic [31:0] b);
    case (oprn)
      6'd1: return a + b;
      6'd2: return a - b;
      6'd3: return a * b;
      6'd4: return a >> b;
      6'd5: return a << b;
      6'd6: return a & b;
      6'd7: return a | b;
      6'd8: return ~(a | b);
      6'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign aluOutA  = aluModel(aluOprnA, aluOp1A, aluOp2A);
  assign aluZeroA = (aluOutA == 32'd0);
  assign aluOutB  = aluModel(aluOprnB, aluOp1B, aluOp2B);
  assign aluZeroB = (aluOutB == 32'd0);

  alu_issue_ctrl #(.DATA_W(32), .OPRN_W(6), .SETTLE_CYCLES(1)) u_dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_req_valid(reqValidA), .o_req_ready(reqReadyA),
    .i_instr(instrA), .i_rs_data(rsDataA), .i_rt_data(rtDataA),
    .o_alu_op1(aluOp1A), .o_alu_op2(aluOp2A), .o_alu_oprn(aluOprnA),
    .i_alu_out(aluOutA), .i_alu_zero(aluZeroA),
    .o_rsp_valid(rspValidA), .i_rsp_ready(rspReadyA),
    .o_rsp_data(rspDataA), .o_rsp_zero(rspZeroA), .o_rsp_err(rspErrA)
  );

  alu_issue_ctrl #(.DATA_W(32), .OPRN_W(6), .SETTLE_CYCLES(3)) u_dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_req_valid(reqValidB), .o_req_ready(reqReadyB),
    .i_instr(instrB), .i_rs_data(rsDataB), .i_rt_data(rtDataB),
    .o_alu_op1(aluOp1B), .o_alu_op2(aluOp2B), .o_alu_oprn(aluOprnB),
    .i_alu_out(aluOutB), .i_alu_zero(aluZeroB),
    .o_rsp_valid(rspValidB), .i_rsp_ready(rspReadyB),
    .o_rsp_data(rspDataB), .o_rsp_zero(rspZeroB), .o_rsp_err(rspErrB)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [31:0] instr, rs, rt, input logic [5:0] oprn,
                                 input logic [31:0] op1, op2, data);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.legal = 1'b1;
    v.oprn = oprn; v.op1 = op1; v.op2 = op2; v.data = data; v.zero = (data == 32'd0);
    return v;
  endfunction

  function automatic vec_t mkIllegal(input logic [31:0] instr, rs, rt);
    vec_t v;
    v.instr = instr; v.rs = rs; v.rt = rt; v.legal = 1'b0;
    v.oprn = '0; v.op1 = '0; v.op2 = '0; v.data = '0; v.zero = 1'b0;
    return v;
  endfunction

  // Runs one full request/response on instance A, starting 1 time unit after a rising edge in IDLE.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, " reqReady idle"}, reqReadyA, 1);
    reqValidA = 1'b1; instrA = v.instr; rsDataA = v.rs; rtDataA = v.rt;
    @(posedge clk); #1;
    reqValidA = 1'b0; instrA = 32'hFC00_0000; rsDataA = 32'hDEAD_BEEF; rtDataA = 32'hCAFE_F00D;
    checkOutput({tag, " reqReady busy"}, reqReadyA, 0);
    if (v.legal) begin
      heldOprn = v.oprn; heldOp1 = v.op1; heldOp2 = v.op2;
      checkOutput({tag, " rspValid early"}, rspValidA, 0);
      @(posedge clk); #1;
    end
    checkOutput({tag, " aluOprn"}, aluOprnA, heldOprn);
    checkOutput({tag, " aluOp1"}, aluOp1A, heldOp1);
    checkOutput({tag, " aluOp2"}, aluOp2A, heldOp2);
    checkOutput({tag, " rspValid"}, rspValidA, 1);
    checkOutput({tag, " rspData"}, rspDataA, v.data);
    checkOutput({tag, " rspZero"}, rspZeroA, v.zero);
    checkOutput({tag, " rspErr"}, rspErrA, !v.legal);
    rspReadyA = 1'b1;
    @(posedge clk); #1;
    rspReadyA = 1'b0;
    checkOutput({tag, " rspValid done"}, rspValidA, 0);
    checkOutput({tag, " reqReady done"}, reqReadyA, 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0;
    reqValidA = 0; instrA = '0; rsDataA = '0; rtDataA = '0; rspReadyA = 0;
    reqValidB = 0; instrB = '0; rsDataB = '0; rtDataB = '0; rspReadyB = 0;
    heldOprn = '0; heldOp1 = '0; heldOp2 = '0;

    vecs.push_back(mkVec(32'h0022_1820, 32'd5, 32'd7, 6'd1, 32'd5, 32'd7, 32'd12));
    vecs.push_back(mkVec(32'h1022_0003, 32'h1234, 32'h1234, 6'd2, 32'h1234, 32'h1234, 32'd0));
    vecs.push_back(mkVec(32'h0001_1100, 32'h99, 32'd1, 6'd5, 32'd1, 32'd4, 32'h10));
    vecs.push_back(mkVec(32'h0000_07C2, 32'h55, 32'h8000_0000, 6'd4, 32'h8000_0000, 32'd31, 32'd1));
    vecs.push_back(mkIllegal(32'hFC00_0000, 32'd1, 32'd2));
    vecs.push_back(mkVec(32'h0000_0022, 32'd10, 32'd10, 6'd2, 32'd10, 32'd10, 32'd0));
    vecs.push_back(mkVec(32'h0000_002C, 32'h1_0000, 32'h1_0003, 6'd3, 32'h1_0000, 32'h1_0003, 32'h0003_0000));
    vecs.push_back(mkVec(32'h0000_0024, 32'hF0F0_FFFF, 32'h0FF0_00FF, 6'd6, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF));
    vecs.push_back(mkVec(32'h0000_0025, 32'hF000_0000, 32'h0000_000F, 6'd7, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F));
    vecs.push_back(mkVec(32'h0000_0027, 32'hFFFF_0000, 32'h0000_FF00, 6'd8, 32'hFFFF_0000, 32'h0000_FF00, 32'h0000_00FF));
    vecs.push_back(mkVec(32'h0000_002A, 32'hFFFF_FFFF, 32'd1, 6'd9, 32'hFFFF_FFFF, 32'd1, 32'd1));
    vecs.push_back(mkVec(32'h1400_0000, 32'd3, 32'd3, 6'd2, 32'd3, 32'd3, 32'd0));
    vecs.push_back(mkIllegal(32'h0000_003F, 32'd4, 32'd5));
`ifdef ALU_ISSUE_IMM_EN
    vecs.push_back(mkVec(32'h2000_FFFF, 32'd3, 32'd0, 6'd1, 32'd3, 32'hFFFF_FFFF, 32'd2));
    vecs.push_back(mkVec(32'h2800_8000, 32'hFFFF_0000, 32'd0, 6'd9, 32'hFFFF_0000, 32'hFFFF_8000, 32'd1));
    vecs.push_back(mkVec(32'h3400_8001, 32'h1000_0000, 32'd0, 6'd7, 32'h1000_0000, 32'h0000_8001, 32'h1000_8001));
    vecs.push_back(mkVec(32'h3C00_1234, 32'h7777_7777, 32'd0, 6'd7, 32'd0, 32'h1234_0000, 32'h1234_0000));
`else
    vecs.push_back(mkIllegal(32'h2000_FFFF, 32'd3, 32'd0));
    vecs.push_back(mkIllegal(32'h2800_8000, 32'hFFFF_0000, 32'd0));
    vecs.push_back(mkIllegal(32'h3400_8001, 32'h1000_0000, 32'd0));
    vecs.push_back(mkIllegal(32'h3C00_1234, 32'h7777_7777, 32'd0));
`endif

    #3;
    checkOutput("reset reqReadyA", reqReadyA, 1);
    checkOutput("reset rspValidA", rspValidA, 0);
    checkOutput("reset aluOprnA", aluOprnA, 0);
    checkOutput("reset rspDataA", rspDataA, 0);
    checkOutput("reset rspErrA", rspErrA, 0);
    checkOutput("reset reqReadyB", reqReadyB, 1);
    checkOutput("reset aluOp1B", aluOp1B, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    $display("[TB] settle window and response back-pressure on SETTLE_CYCLES=3");
    checkOutput("B reqReady idle", reqReadyB, 1);
    reqValidB = 1'b1; instrB = 32'h0022_1820; rsDataB = 32'd100; rtDataB = 32'd23;
    @(posedge clk); #1;
    instrB = 32'hFC00_0000; rsDataB = 32'd0; rtDataB = 32'd0;
    checkOutput("B reqReady after accept", reqReadyB, 0);
    checkOutput("B aluOprn", aluOprnB, 1);
    for (int e = 1; e <= 3; e++) begin
      checkOutput($sformatf("B rspValid before edge %0d", e), rspValidB, 0);
      @(posedge clk); #1;
    end
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("B rspValid hold%0d", k), rspValidB, 1);
      checkOutput($sformatf("B rspData hold%0d", k), rspDataB, 32'd123);
      checkOutput($sformatf("B rspZero hold%0d", k), rspZeroB, 0);
      checkOutput($sformatf("B rspErr hold%0d", k), rspErrB, 0);
      checkOutput($sformatf("B reqReady hold%0d", k), reqReadyB, 0);
      @(posedge clk); #1;
    end
    rspReadyB = 1'b1;
    @(posedge clk); #1;
    rspReadyB = 1'b0;
    reqValidB = 1'b0;
    checkOutput("B rspValid after handshake", rspValidB, 0);
    checkOutput("B reqReady after handshake", reqReadyB, 1);
    @(posedge clk); #1;
    checkOutput("B no accept on completing edge", rspValidB, 0);
    checkOutput("B rspErr untouched", rspErrB, 0);

    $display("[TB] asynchronous reset during DRIVE");
    reqValidB = 1'b1; instrB = 32'h0022_1820; rsDataB = 32'd9; rtDataB = 32'd9;
    @(posedge clk); #1;
    reqValidB = 1'b0;
    @(posedge clk); #1;
    checkOutput("B in DRIVE reqReady", reqReadyB, 0);
    checkOutput("B in DRIVE aluOp1", aluOp1B, 32'd9);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst reqReadyB", reqReadyB, 1);
    checkOutput("rst rspValidB", rspValidB, 0);
    checkOutput("rst aluOp1B", aluOp1B, 0);
    checkOutput("rst aluOp2B", aluOp2B, 0);
    checkOutput("rst aluOprnB", aluOprnB, 0);
    checkOutput("rst rspDataB", rspDataB, 0);
    checkOutput("rst aluOprnA", aluOprnA, 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post-rst no response", rspValidB, 0);
    checkOutput("post-rst reqReadyB", reqReadyB, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
